// File: rtl/debounce_2input.sv
// Two-channel switch/button conditioner: each raw input is brought into the
// clk domain through a two-flop synchronizer, then qualified by a counter FSM
// that only accepts a level after it has held for CNT_MAX consecutive cycles.
// Debounced levels output1/output2 feed orgate_2input input1/input2 directly;
// rise/fall strobes are single-cycle and registered alongside the level.

// One debounced channel: synchronizer, stability FSM and edge strobes.
module debounce_2input_chan #(
    parameter int CNT_MAX   = 1000000,
    parameter int CNT_WIDTH = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // Terminal count: the cycle on which a waiting level is finally accepted.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    logic                 s1_p0;
    logic                 s2_p1;

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 level_q;
    logic                 level_d;
    logic                 rise_q;
    logic                 rise_d;
    logic                 fall_q;
    logic                 fall_d;

    // Counter advance clamped at the terminal count so it can never wrap,
    // even if the FSM were to stay in a WAIT state past acceptance.
    function automatic logic [CNT_WIDTH-1:0] cnt_step(input logic [CNT_WIDTH-1:0] c);
        logic [CNT_WIDTH-1:0] r;
        if (c >= CNT_LAST) begin
            r = CNT_LAST;
        end else begin
            r = c + CNT_WIDTH'(1);
        end
        return r;
    endfunction

    // ---- stage p0/p1: two-flop synchronizer on the asynchronous raw input
    // Synchronizer chain raw -> s1 -> s2; cleared by reset so a held input
    // is re-qualified from scratch after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_p0 <= 1'b0;
            s2_p1 <= 1'b0;
        end else begin
            s1_p0 <= raw;
            s2_p1 <= s1_p0;
        end
    end

    // ---- stage p2: stability FSM, counter and registered outputs
    // State, counter, level and strobe registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: the counter is zero outside WAIT states and restarts
    // from zero on every entry, so any bounce resets the qualification window.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            ST_LOW: begin
                level_d = 1'b0;
                if (s2_p1) begin
                    state_d = ST_WAIT_HIGH;
                end
            end

            ST_WAIT_HIGH: begin
                level_d = 1'b0;
                if (!s2_p1) begin
                    state_d = ST_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_step(cnt_q);
                end
            end

            ST_HIGH: begin
                level_d = 1'b1;
                if (!s2_p1) begin
                    state_d = ST_WAIT_LOW;
                end
            end

            ST_WAIT_LOW: begin
                level_d = 1'b1;
                if (s2_p1) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_step(cnt_q);
                end
            end

            default: begin
                state_d = ST_LOW;
                level_d = 1'b0;
            end
        endcase
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// Top level: two fully independent channels sharing only clock and reset.
module debounce_2input #(
    parameter int CNT_MAX   = 1000000,
    parameter int CNT_WIDTH = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic input1,
    input  logic input2,
    output logic output1,
    output logic output2,
    output logic rise1,
    output logic rise2,
    output logic fall1,
    output logic fall2
);

    debounce_2input_chan #(
        .CNT_MAX   (CNT_MAX),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ch1 (
        .clk   (clk),
        .rst   (rst),
        .raw   (input1),
        .level (output1),
        .rise  (rise1),
        .fall  (fall1)
    );

    debounce_2input_chan #(
        .CNT_MAX   (CNT_MAX),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ch2 (
        .clk   (clk),
        .rst   (rst),
        .raw   (input2),
        .level (output2),
        .rise  (rise2),
        .fall  (fall2)
    );

endmodule

// File: tb/tb_debounce_2input.sv
// Directed bench for debounce_2input with CNT_MAX=4. Each step drives the
// inputs, queues the expected output vector for every following edge, then
// clocks the DUT and compares each popped expectation against the outputs.
// Vector layout: {output1, output2, rise1, rise2, fall1, fall2}.
module tb_debounce_2input;

    localparam int CNT_MAX   = 4;
    localparam int CNT_WIDTH = 20;

    logic clk = 1'b0;
    logic rst;
    logic input1;
    logic input2;
    logic output1;
    logic output2;
    logic rise1;
    logic rise2;
    logic fall1;
    logic fall2;

    typedef struct {
        string      tag;
        logic [5:0] vec;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    debounce_2input #(
        .CNT_MAX   (CNT_MAX),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .input1  (input1),
        .input2  (input2),
        .output1 (output1),
        .output2 (output2),
        .rise1   (rise1),
        .rise2   (rise2),
        .fall1   (fall1),
        .fall2   (fall2)
    );

    always #5 clk = ~clk;

    // Queue n identical expectations, one per upcoming clock edge.
    task automatic push(input string tag, input int n, input logic [5:0] v);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag = $sformatf("%s[%0d]", tag, i);
            e.vec = v;
            sb.push_back(e);
        end
    endtask

    // Clock once per queued expectation and compare 1 ns after the edge.
    task automatic drain();
        exp_t       e;
        logic [5:0] obs;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            obs = {output1, output2, rise1, rise2, fall1, fall2};
            vectors++;
            assert (obs === e.vec) else begin
                miscompares++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        input1 = 1'b0;
        input2 = 1'b0;

        // Reset for three edges, then idle with both inputs low.
        push("reset", 3, 6'b000000);
        drain();
        rst = 1'b0;
        push("idle", 4, 6'b000000);
        drain();

        // Channel 1 clean rise: output after the 7th edge, one-cycle rise1.
        input1 = 1'b1;
        push("rise1_wait", 6, 6'b000000);
        push("rise1_edge", 1, 6'b101000);
        push("rise1_hold", 3, 6'b100000);
        drain();

        // Channel 2 three-cycle high glitch: rejected, no pulse.
        input2 = 1'b1;
        push("glitch2_hi", 3, 6'b100000);
        drain();
        input2 = 1'b0;
        push("glitch2_lo", 6, 6'b100000);
        drain();

        // Channel 2 held high: accepted exactly 7 edges later.
        input2 = 1'b1;
        push("rise2_wait", 6, 6'b100000);
        push("rise2_edge", 1, 6'b110100);
        push("rise2_hold", 2, 6'b110000);
        drain();

        // Channel 1 clean fall: fall1 pulse after 7 edges.
        input1 = 1'b0;
        push("fall1_wait", 6, 6'b110000);
        push("fall1_edge", 1, 6'b010010);
        push("fall1_hold", 2, 6'b010000);
        drain();

        // Restore channel 1 high.
        input1 = 1'b1;
        push("rerise1_wait", 6, 6'b010000);
        push("rerise1_edge", 1, 6'b111000);
        push("rerise1_hold", 2, 6'b110000);
        drain();

        // Two-cycle low glitch on channel 1: output stays high, no fall1.
        input1 = 1'b0;
        push("glitch1_lo", 2, 6'b110000);
        drain();
        input1 = 1'b1;
        push("glitch1_hi", 8, 6'b110000);
        drain();

        // Both channels fall together: same-cycle fall pulses.
        input1 = 1'b0;
        input2 = 1'b0;
        push("bothfall_wait", 6, 6'b110000);
        push("bothfall_edge", 1, 6'b000011);
        push("bothfall_hold", 2, 6'b000000);
        drain();

        // Both channels rise together: same-cycle rise pulses.
        input1 = 1'b1;
        input2 = 1'b1;
        push("bothrise_wait", 6, 6'b000000);
        push("bothrise_edge", 1, 6'b111100);
        push("bothrise_hold", 2, 6'b110000);
        drain();

        // Bring both low again before the reset scenarios.
        input1 = 1'b0;
        input2 = 1'b0;
        push("prerst_wait", 6, 6'b110000);
        push("prerst_edge", 1, 6'b000011);
        push("prerst_hold", 2, 6'b000000);
        drain();

        // Reset mid-count: five edges puts channel 1 in WAIT_HIGH with cnt=2.
        input1 = 1'b1;
        push("midcnt_wait", 5, 6'b000000);
        drain();
        rst = 1'b1;
        push("midcnt_rst", 1, 6'b000000);
        drain();
        rst = 1'b0;
        push("postrst_wait", 6, 6'b000000);
        push("postrst_edge", 1, 6'b101000);
        push("postrst_hold", 2, 6'b100000);
        drain();

        // Reset while HIGH: output drops without a fall pulse, then requalifies.
        rst = 1'b1;
        push("highrst", 1, 6'b000000);
        drain();
        rst = 1'b0;
        push("highrst_wait", 6, 6'b000000);
        push("highrst_edge", 1, 6'b101000);
        push("highrst_hold", 2, 6'b100000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
